// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the 16x16 register set.
// The arbiter takes the slave side; whoever drives the requests takes the master side.
interface regfile_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 4
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 regWrite;
    logic [(2**AW)-1:0]   decOut;
    logic [DW-1:0]        writeData;
    logic [2:0]           grant_id;
    logic [15:0]          wr_count;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, regWrite, decOut, writeData, grant_id, wr_count
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, regWrite, decOut, writeData, grant_id, wr_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-set write port: grants one requester per
// cycle and replays the granted write onto regWrite/decOut/writeData one cycle later.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DECW = 2**AW;

    logic [PW-1:0]   rrPtr;
    logic [NREQ-1:0] grantVec;
    logic [PW-1:0]   winIdx;
    logic            anyGrant;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;

    logic            regWriteQ;
    logic [DECW-1:0] decOutQ;
    logic [DW-1:0]   writeDataQ;
    logic [2:0]      grantIdQ;
    logic [15:0]     wrCount;

    // Search starts at rrPtr and wraps; the first valid requester found wins.
    always_comb begin
        grantVec = '0;
        winIdx   = '0;
        anyGrant = 1'b0;
        if (reset && !bus.hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!anyGrant && bus.req_valid[(int'(rrPtr) + k) % NREQ]) begin
                    anyGrant = 1'b1;
                    winIdx   = PW'((int'(rrPtr) + k) % NREQ);
                end
            end
            if (anyGrant) begin
                grantVec[winIdx] = 1'b1;
            end
        end
    end

    assign selAddr = bus.req_addr[winIdx*AW +: AW];
    assign selData = bus.req_data[winIdx*DW +: DW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr      <= '0;
            regWriteQ  <= 1'b0;
            decOutQ    <= '0;
            writeDataQ <= '0;
            grantIdQ   <= '0;
            wrCount    <= '0;
        end else if (anyGrant) begin
            regWriteQ  <= 1'b1;
            decOutQ    <= DECW'(1) << selAddr;
            writeDataQ <= selData;
            grantIdQ   <= 3'(winIdx);
            wrCount    <= wrCount + 16'd1;
            rrPtr      <= (winIdx == PW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
        end else begin
            // Idle cycle: strobe and select drop, data/id keep showing the last write.
            regWriteQ  <= 1'b0;
            decOutQ    <= '0;
        end
    end

    assign bus.req_ready = grantVec;
    assign bus.regWrite  = regWriteQ;
    assign bus.decOut    = decOutQ;
    assign bus.writeData = writeDataQ;
    assign bus.grant_id  = grantIdQ;
    assign bus.wr_count  = wrCount;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table with hand-derived grants, a scoreboard
// queue for the issue stage, plus hand sequences for mid-stream reset and counter wrap.
module tb_regfile_write_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        hold;
        logic [15:0] addr;
        logic [63:0] data;
        logic [3:0]  expReady;
    } vec_t;

    typedef struct {
        logic [15:0] dec;
        logic [15:0] data;
        logic [2:0]  id;
    } wr_t;

    wr_t         sbq[$];
    vec_t        tbl[27];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] expCount = '0;
    logic [15:0] lastData = '0;
    logic [2:0]  lastId   = '0;

    function automatic vec_t mkv(input logic [3:0] v, input logic h, input logic [15:0] a,
                                 input logic [63:0] d, input logic [3:0] r);
        vec_t x;
        x.valid = v; x.hold = h; x.addr = a; x.data = d; x.expReady = r;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIssue();
        if (sbq.size() > 0) begin
            wr_t w;
            w = sbq.pop_front();
            chk("regWrite_on", 64'(bus.regWrite), 64'(1'b1));
            chk("decOut", 64'(bus.decOut), 64'(w.dec));
            chk("writeData", 64'(bus.writeData), 64'(w.data));
            chk("grant_id", 64'(bus.grant_id), 64'(w.id));
            lastData = w.data;
            lastId   = w.id;
        end else begin
            chk("regWrite_off", 64'(bus.regWrite), 64'(1'b0));
            chk("decOut_off", 64'(bus.decOut), 64'(0));
            chk("writeData_hold", 64'(bus.writeData), 64'(lastData));
            chk("grant_id_hold", 64'(bus.grant_id), 64'(lastId));
        end
        chk("wr_count", 64'(bus.wr_count), 64'(expCount));
    endtask

    task automatic applyVec(input vec_t v);
        int idx;
        wr_t w;
        idx = 0;
        @(negedge clk);
        bus.hold      = v.hold;
        bus.req_valid = v.valid;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(v.expReady));
        if (v.expReady != 4'b0000) begin
            for (int i = 0; i < NREQ; i++) if (v.expReady[i]) idx = i;
            w.dec  = 16'(1) << v.addr[idx*AW +: AW];
            w.data = v.data[idx*DW +: DW];
            w.id   = 3'(idx);
            sbq.push_back(w);
            expCount++;
        end
        @(posedge clk);
        #1;
        checkIssue();
    endtask

    initial begin
        int n;
        // rr pointer traced by hand: it starts at 0 and becomes winner+1 after each grant.
        tbl[0]  = mkv(4'b1111, 1'b0, 16'h3210, 64'h4444_3333_2222_1111, 4'b0001);
        tbl[1]  = mkv(4'b1111, 1'b0, 16'h3210, 64'h4444_3333_2222_1111, 4'b0010);
        tbl[2]  = mkv(4'b1111, 1'b0, 16'h3210, 64'h4444_3333_2222_1111, 4'b0100);
        tbl[3]  = mkv(4'b1111, 1'b0, 16'h3210, 64'h4444_3333_2222_1111, 4'b1000);
        tbl[4]  = mkv(4'b1111, 1'b0, 16'hBA98, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0001);
        tbl[5]  = mkv(4'b1111, 1'b0, 16'hBA98, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0010);
        tbl[6]  = mkv(4'b1111, 1'b0, 16'hBA98, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0100);
        tbl[7]  = mkv(4'b1111, 1'b0, 16'hBA98, 64'hDDDD_CCCC_BBBB_AAAA, 4'b1000);
        tbl[8]  = mkv(4'b0100, 1'b0, 16'h0900, 64'h0000_A5C3_0000_0000, 4'b0100);
        tbl[9]  = mkv(4'b0000, 1'b0, 16'h0000, 64'h0,                   4'b0000);
        tbl[10] = mkv(4'b0010, 1'b1, 16'h0060, 64'h0000_0000_6666_0000, 4'b0000);
        tbl[11] = mkv(4'b0010, 1'b1, 16'h0060, 64'h0000_0000_6666_0000, 4'b0000);
        tbl[12] = mkv(4'b0010, 1'b1, 16'h0060, 64'h0000_0000_6666_0000, 4'b0000);
        tbl[13] = mkv(4'b0010, 1'b0, 16'h0060, 64'h0000_0000_6666_0000, 4'b0010);
        tbl[14] = mkv(4'b0001, 1'b0, 16'h000F, 64'h0000_0000_0000_1111, 4'b0001);
        tbl[15] = mkv(4'b1000, 1'b0, 16'hF000, 64'h2222_0000_0000_0000, 4'b1000);
        tbl[16] = mkv(4'b0000, 1'b0, 16'h0000, 64'h0,                   4'b0000);
        tbl[17] = mkv(4'b0100, 1'b0, 16'h0500, 64'h0000_5501_0000_0000, 4'b0100);
        tbl[18] = mkv(4'b0100, 1'b0, 16'h0500, 64'h0000_5502_0000_0000, 4'b0100);
        tbl[19] = mkv(4'b0100, 1'b0, 16'h0500, 64'h0000_5503_0000_0000, 4'b0100);
        tbl[20] = mkv(4'b0011, 1'b0, 16'h0021, 64'h0000_0000_BBBB_AAAA, 4'b0001);
        tbl[21] = mkv(4'b0010, 1'b0, 16'h0021, 64'h0000_0000_BBBB_AAAA, 4'b0010);
        tbl[22] = mkv(4'b1010, 1'b0, 16'h7030, 64'h7777_0000_1313_0000, 4'b1000);
        tbl[23] = mkv(4'b0110, 1'b0, 16'h0C40, 64'h0000_CCCC_4444_0000, 4'b0010);
        tbl[24] = mkv(4'b1111, 1'b1, 16'h1234, 64'h0404_0303_0202_0101, 4'b0000);
        tbl[25] = mkv(4'b1111, 1'b0, 16'h1234, 64'h0404_0303_0202_0101, 4'b0100);
        tbl[26] = mkv(4'b0000, 1'b0, 16'h0000, 64'h0,                   4'b0000);

        bus.hold = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        #3 reset = 1'b0;
        bus.req_valid = 4'b1111;
        #9;
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_regWrite", 64'(bus.regWrite), 64'(0));
        chk("rst_decOut", 64'(bus.decOut), 64'(0));
        chk("rst_writeData", 64'(bus.writeData), 64'(0));
        chk("rst_grant_id", 64'(bus.grant_id), 64'(0));
        chk("rst_wr_count", 64'(bus.wr_count), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;

        applyVec(mkv(4'b0110, 1'b0, 16'h0870, 64'h0000_8888_7777_0000, 4'b0010));
        applyVec(mkv(4'b0110, 1'b0, 16'h0870, 64'h0000_8888_7777_0000, 4'b0100));

        // Mid-stream reset with req0 still valid and its write on the port.
        @(negedge clk);
        bus.req_valid = 4'b0001; bus.req_addr = 16'h0003; bus.req_data = 64'h0000_0000_0000_3333;
        #1 chk("pre_rst_ready", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk);
        #1 chk("pre_rst_regWrite", 64'(bus.regWrite), 64'(1'b1));
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
        chk("mid_rst_regWrite", 64'(bus.regWrite), 64'(0));
        chk("mid_rst_decOut", 64'(bus.decOut), 64'(0));
        chk("mid_rst_writeData", 64'(bus.writeData), 64'(0));
        chk("mid_rst_grant_id", 64'(bus.grant_id), 64'(0));
        chk("mid_rst_wr_count", 64'(bus.wr_count), 64'(0));
        sbq.delete();
        expCount = '0; lastData = '0; lastId = '0;
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;

        for (int i = 0; i < 27; i++) applyVec(tbl[i]);

        // Sustained traffic up to 16'hFFFF, then one more write must wrap to zero.
        n = 16'hFFFF - int'(expCount);
        @(negedge clk);
        bus.hold = 1'b0; bus.req_valid = 4'b1111;
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        expCount = expCount + 16'(n);
        chk("wr_count_max", 64'(bus.wr_count), 64'(16'hFFFF));
        @(posedge clk);
        #1 lastData = bus.writeData;
        lastId = bus.grant_id;
        applyVec(mkv(4'b1000, 1'b0, 16'h5000, 64'h9999_0000_0000_0000, 4'b1000));
        chk("wr_count_wrap", 64'(bus.wr_count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
